// File: rtl/pc_ret_stack_unit_pkg.sv
// Shared definitions for the program counter / return-address stack unit.
// pc_op_e enumerates the single operation performed on each falling edge;
// pc_op_sel() is the fixed-priority encoder from decoder strobes to that
// operation. The decoder and the testbench use the same package.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_JMP,
        OP_CALL,
        OP_RET,
        OP_RETI,
        OP_INT
    } pc_op_e;

    // Priority: INT (unmasked) > RETI > RET > CALL > JMP > INC > HOLD.
    // A masked interrupt request simply falls through to the lower ops.
    function automatic pc_op_e pc_op_sel(
        input logic int_req,
        input logic int_active,
        input logic reti,
        input logic ret,
        input logic call,
        input logic jmp,
        input logic pcpp
    );
        pc_op_e op;
        if (int_req && !int_active) op = OP_INT;
        else if (reti)              op = OP_RETI;
        else if (ret)               op = OP_RET;
        else if (call)              op = OP_CALL;
        else if (jmp)               op = OP_JMP;
        else if (pcpp)              op = OP_INC;
        else                        op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/pc_ret_stack_unit_stack.sv
// pc_ret_stack: DEPTH x AW LIFO holding return addresses.
// Ports:
//   CLK    falling-edge clock
//   RST    asynchronous active-high reset; clears the stack pointer only
//   push   write din at the top (ignored when full)
//   pop    discard the top entry (ignored when empty)
//   din    address to push
//   dout   current top entry (valid only when not empty)
//   sp     number of entries in use, 0..DEPTH
//   full   sp == DEPTH
//   empty  sp == 0
// push and pop must not be asserted together.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            din,
    output logic [AW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_m1;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        full    = (sp_q == SPW'(DEPTH));
        empty   = (sp_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        sp_m1   = sp_q - SPW'(1);
        // Low IW bits of sp-1 address the top slot; meaningless when empty.
        dout    = mem[sp_m1[IW-1:0]];
        sp      = sp_q;
    end

    // Storage carries no reset; contents are undefined until written.
    always_ff @(negedge CLK) begin
        if (do_push) begin
            mem[sp_q[IW-1:0]] <= din;
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            sp_q <= '0;
        end else if (do_push) begin
            sp_q <= sp_q + SPW'(1);
        end else if (do_pop) begin
            sp_q <= sp_m1;
        end
    end

endmodule

// File: rtl/pc_ret_stack_unit.sv
// pc_ret_stack_unit: program counter with integrated return-address stack.
// Sits between the instruction decoder and the program memory address bus.
// All state changes on the falling edge of CLK; RST is async, active-high.
// Ports:
//   CLK, RST     clock (falling edge active), reset
//   PCpp         increment PC
//   JMP          jump to Imm
//   CALL         push ADDRout+1, jump to Imm
//   RET          pop top of stack into ADDRout
//   RETI         as RET, also clears INT_ACTIVE
//   INTjmp       interrupt request: push ADDRout, jump to Aint (masked while INT_ACTIVE)
//   CLR_ERR      clear sticky OVF/UNF (a same-edge new error wins)
//   Imm, Aint    jump/call target, interrupt vector
//   ADDRout      registered program address
//   SP           stack entries in use; FULL/EMPTY decoded from it
//   OVF, UNF     sticky push-while-full / pop-while-empty flags
//   INT_ACTIVE   ISR in progress
//   INT_ACK      one-cycle pulse on the edge an interrupt is taken
module pc_ret_stack_unit
    import pc_pkg::*;
#(
    parameter int             AW        = 16,
    parameter int             DEPTH     = 8,
    parameter logic [AW-1:0]  RESET_VEC = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    PCpp,
    input  logic                    JMP,
    input  logic                    CALL,
    input  logic                    RET,
    input  logic                    RETI,
    input  logic                    INTjmp,
    input  logic                    CLR_ERR,
    input  logic [AW-1:0]           Imm,
    input  logic [AW-1:0]           Aint,
    output logic [AW-1:0]           ADDRout,
    output logic [$clog2(DEPTH):0]  SP,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    OVF,
    output logic                    UNF,
    output logic                    INT_ACTIVE,
    output logic                    INT_ACK
);

    pc_op_e        op;
    logic          push_req;
    logic          pop_req;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] stk_din;
    logic [AW-1:0] stk_top;

    always_comb begin
        op       = pc_op_sel(INTjmp, INT_ACTIVE, RETI, RET, CALL, JMP, PCpp);
        push_req = (op == OP_INT) || (op == OP_CALL);
        pop_req  = (op == OP_RET) || (op == OP_RETI);
        addr_inc = ADDRout + AW'(1);
        // Interrupt saves the interrupted address so that instruction re-executes.
        stk_din  = (op == OP_INT) ? ADDRout : addr_inc;
    end

    pc_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push_req),
        .pop   (pop_req),
        .din   (stk_din),
        .dout  (stk_top),
        .sp    (SP),
        .full  (FULL),
        .empty (EMPTY)
    );

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            ADDRout    <= RESET_VEC;
            OVF        <= 1'b0;
            UNF        <= 1'b0;
            INT_ACTIVE <= 1'b0;
            INT_ACK    <= 1'b0;
        end else begin
            INT_ACK <= (op == OP_INT);

            case (op)
                OP_INT: begin
                    ADDRout    <= Aint;
                    INT_ACTIVE <= 1'b1;
                end
                OP_CALL, OP_JMP: ADDRout <= Imm;
                OP_INC:          ADDRout <= addr_inc;
                OP_RET, OP_RETI: begin
                    if (!EMPTY) begin
                        ADDRout <= stk_top;
                    end
                    if (op == OP_RETI) begin
                        INT_ACTIVE <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (push_req && FULL) begin
                OVF <= 1'b1;
            end else if (CLR_ERR) begin
                OVF <= 1'b0;
            end

            if (pop_req && EMPTY) begin
                UNF <= 1'b1;
            end else if (CLR_ERR) begin
                UNF <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_ret_stack_unit.sv
module tb_pc_ret_stack_unit;
    import pc_pkg::*;

    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam logic [AW-1:0] RVEC = 16'h0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pcpp = 0, jmp = 0, call = 0, ret = 0, reti = 0, intj = 0, clr = 0;
    logic [AW-1:0] imm = '0, aint = '0;
    logic [AW-1:0] addr;
    logic [3:0]    sp;
    logic          full, empty, ovf, unf, iact, iack;

    int total = 0;
    int bad   = 0;

    pc_ret_stack_unit #(
        .AW        (AW),
        .DEPTH     (DEPTH),
        .RESET_VEC (RVEC)
    ) dut (
        .CLK(clk), .RST(rst), .PCpp(pcpp), .JMP(jmp), .CALL(call), .RET(ret),
        .RETI(reti), .INTjmp(intj), .CLR_ERR(clr), .Imm(imm), .Aint(aint),
        .ADDRout(addr), .SP(sp), .FULL(full), .EMPTY(empty), .OVF(ovf),
        .UNF(unf), .INT_ACTIVE(iact), .INT_ACK(iack)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_stk[$];
    logic          m_ovf, m_unf, m_ia, m_ack;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_addr = RVEC;
            m_stk.delete();
            m_ovf = 0; m_unf = 0; m_ia = 0; m_ack = 0;
        end else begin
            m_ack = 0;
            if (clr) begin m_ovf = 0; m_unf = 0; end
            if (intj && !m_ia) begin
                if (m_stk.size() == DEPTH) m_ovf = 1;
                else m_stk.push_back(m_addr);
                m_addr = aint; m_ia = 1; m_ack = 1;
            end else if (reti || ret) begin
                if (m_stk.size() == 0) m_unf = 1;
                else m_addr = m_stk.pop_back();
                if (reti) m_ia = 0;
            end else if (call) begin
                if (m_stk.size() == DEPTH) m_ovf = 1;
                else m_stk.push_back(m_addr + 16'd1);
                m_addr = imm;
            end else if (jmp) begin
                m_addr = imm;
            end else if (pcpp) begin
                m_addr = m_addr + 16'd1;
            end
        end
    end

    // Compare DUT with model on every rising edge (mid-cycle) outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            logic [AW+9:0] exp_v, act_v;
            exp_v = {m_addr, 4'(m_stk.size()), m_stk.size() == DEPTH, m_stk.size() == 0,
                     m_ovf, m_unf, m_ia, m_ack};
            act_v = {addr, sp, full, empty, ovf, unf, iact, iack};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp_v);
        end
    endtask

    // Hold strobes across exactly one falling edge, then clear them.
    task automatic step(input logic [6:0] s, input logic [AW-1:0] i, input logic [AW-1:0] a,
                        input logic c);
        {intj, reti, ret, call, jmp, pcpp, clr} = s;
        if (c) clr = 1;
        imm = i; aint = a;
        @(negedge clk); #1;
        {intj, reti, ret, call, jmp, pcpp, clr} = '0;
    endtask

    // strobe bit positions: {intj, reti, ret, call, jmp, pcpp, clr}
    localparam logic [6:0] S_INT = 7'b1000000, S_RETI = 7'b0100000, S_RET = 7'b0010000,
                           S_CALL = 7'b0001000, S_JMP = 7'b0000100, S_INC = 7'b0000010,
                           S_CLR = 7'b0000001, S_NONE = 7'b0000000;

    initial begin
        #12;
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_flags", {26'd0, ovf, unf, iact, iack, full, empty}, 32'h1);
        chk("rst_sp", 32'(sp), 32'd0);
        rst = 0;

        step(S_JMP, 16'h0010, '0, 0);
        chk("jmp", 32'(addr), 32'h0010);
        step(S_CALL, 16'h0200, '0, 0);
        chk("call_addr", 32'(addr), 32'h0200);
        chk("call_sp", 32'(sp), 32'd1);
        step(S_RET, '0, '0, 0);
        chk("ret_addr", 32'(addr), 32'h0011);
        chk("ret_sp", 32'(sp), 32'd0);

        step(S_JMP, 16'h0123, '0, 0);
        step(S_INT, '0, 16'h0F00, 0);
        chk("int_addr", 32'(addr), 32'h0F00);
        chk("int_ack", {30'd0, iack, iact}, 32'h3);
        step(S_NONE, '0, '0, 0);
        chk("ack_pulse", 32'(iack), 32'h0);
        step(S_INT | S_INC, '0, 16'h0E00, 0);
        chk("int_masked", 32'(addr), 32'h0F01);
        step(S_RETI, '0, '0, 0);
        chk("reti_addr", 32'(addr), 32'h0123);
        chk("reti_ia", 32'(iact), 32'h0);

        step(S_JMP, 16'h1000, '0, 0);
        for (int i = 0; i <= DEPTH; i++) begin
            step(S_CALL, 16'h2000 + 16'(i), '0, 0);
            if (i == DEPTH - 1) chk("full_at_depth", {30'd0, full, ovf}, 32'h2);
        end
        chk("ovf_addr", 32'(addr), 32'h2008);
        chk("ovf_flags", {28'd0, sp}, 32'd8);
        chk("ovf_set", 32'(ovf), 32'h1);
        step(S_CLR, '0, '0, 0);
        chk("ovf_clr", 32'(ovf), 32'h0);
        step(S_RET, '0, '0, 0);
        chk("ret_top", 32'(addr), 32'h2007);
        for (int i = 1; i < DEPTH; i++) step(S_RET, '0, '0, 0);
        chk("ret_bottom", 32'(addr), 32'h1001);

        step(S_RET, '0, '0, 0);
        chk("unf_addr", 32'(addr), 32'h1001);
        chk("unf_set", {30'd0, unf, empty}, 32'h3);
        step(S_RET, '0, '0, 1);
        chk("unf_wins_clr", 32'(unf), 32'h1);
        step(S_CLR, '0, '0, 0);
        chk("unf_clr", 32'(unf), 32'h0);

        step(S_JMP, 16'hFFFF, '0, 0);
        step(S_INC, '0, '0, 0);
        chk("inc_wrap", 32'(addr), 32'h0000);

        step(S_JMP, 16'h0300, '0, 0);
        step(S_CALL, 16'h0400, '0, 0);
        step(S_INT | S_RET | S_CALL | S_INC, 16'h0500, 16'h0F00, 0);
        chk("prio_int", {12'd0, addr, sp}, {12'd0, 16'h0F00, 4'd2});
        step(S_RET | S_CALL, 16'h0600, '0, 0);
        chk("prio_ret", {12'd0, addr, sp}, {12'd0, 16'h0400, 4'd1});
        step(S_RETI | S_RET, '0, '0, 0);
        chk("prio_reti", {11'd0, iact, addr, sp}, {11'd0, 1'b0, 16'h0301, 4'd0});

        step(S_CALL, 16'h0700, '0, 0);
        step(S_INT, '0, 16'h0F00, 0);
        #3 rst = 1;
        #1;
        chk("midrun_rst", {6'd0, addr, sp, ovf, unf, iact, iack, full, empty},
            {6'd0, RVEC, 4'd0, 6'b000001});
        #2 rst = 0;
        step(S_INC, '0, '0, 0);
        chk("after_rst", 32'(addr), 32'h0001);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
